// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase intersection controller.
// Serves vehicle approaches in the sequence green -> yellow -> all-red and adds a
// latched pedestrian walk phase and emergency preemption. Phase 0 is the main road
// and the rest phase. All durations are counted in tick strobes.
`timescale 1ns/1ps
module traffic_phase_ctrl #(
  parameter int N_PHASE      = 4,
  parameter int PW           = $clog2(N_PHASE),
  parameter int TW           = 8,
  parameter int T_GREEN_MAIN = 60,
  parameter int T_GREEN_SIDE = 40,
  parameter int T_YELLOW     = 5,
  parameter int T_ALLRED     = 5,
  parameter int T_WALK       = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_PHASE-1:0]   veh_req,
  input  logic                 ped_btn,
  input  logic                 preempt,
  input  logic [PW-1:0]        preempt_phase,
  output logic [2*N_PHASE-1:0] light,
  output logic                 walk,
  output logic [PW-1:0]        active_phase,
  output logic                 ped_pending
);

  localparam logic [1:0] GREEN   = 2'd0;
  localparam logic [1:0] YELLOW  = 2'd1;
  localparam logic [1:0] ALL_RED = 2'd2;
  localparam logic [1:0] WALK    = 2'd3;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_RED    = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  // Every phase except the main road; used to decide whether phase 0 must yield.
  localparam logic [N_PHASE-1:0] SIDE_MASK = ~N_PHASE'(1);

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        cur_q, cur_d;
  logic [TW-1:0]        count_q, count_d;
  logic [N_PHASE-1:0]   veh_pend_q, veh_pend_d;
  logic                 ped_q, ped_d;

  logic [TW-1:0]        limit;
  logic                 done;
  logic                 side_pend;
  logic                 preempt_ok;
  logic [(1<<PW)-1:0]   phase_valid;
  logic                 rr_found;
  logic [PW-1:0]        rr_idx;
  logic [PW-1:0]        rr_cand;
  logic [N_PHASE-1:0]   veh_req_eff;

  // A preempt request naming a phase that does not exist is ignored, so the
  // served phase index can never leave 0..N_PHASE-1.
  for (genvar gi = 0; gi < (1 << PW); gi++) begin : g_valid
    assign phase_valid[gi] = (gi < N_PHASE);
  end

  assign preempt_ok = preempt && phase_valid[preempt_phase];
  assign side_pend  = |(veh_pend_q & SIDE_MASK);
  assign done       = (count_q >= limit);

  // Duration of the current state; green depends on main vs side approach.
  always_comb begin
    limit = TW'(T_GREEN_SIDE);
    case (state_q)
      GREEN:   limit = (cur_q == '0) ? TW'(T_GREEN_MAIN) : TW'(T_GREEN_SIDE);
      YELLOW:  limit = TW'(T_YELLOW);
      ALL_RED: limit = TW'(T_ALLRED);
      WALK:    limit = TW'(T_WALK);
      default: limit = TW'(T_GREEN_SIDE);
    endcase
  end

  // Round-robin search for the next waiting approach, starting after cur;
  // scanning from the far end lets the nearest pending phase win.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = N_PHASE - 1; k >= 1; k--) begin
      rr_cand = PW'((int'(cur_q) + k) % N_PHASE);
      if (veh_pend_q[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Phase sequencing: preemption first, then timer expiry and pending demand.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      GREEN: begin
        if (preempt_ok) begin
          // Preempting toward another phase cuts green short; toward us it holds.
          if (preempt_phase != cur_q) state_d = YELLOW;
        end else if (done) begin
          // Main road rests in green until someone else is waiting.
          if ((cur_q != '0) || side_pend || ped_q) state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (done) state_d = ALL_RED;
      end
      WALK: begin
        if (done || preempt_ok) state_d = ALL_RED;
      end
      ALL_RED: begin
        if (done) begin
          if (preempt_ok) begin
            state_d = GREEN;
            cur_d   = preempt_phase;
          end else if (ped_q) begin
            state_d = WALK;
          end else if (rr_found) begin
            state_d = GREEN;
            cur_d   = rr_idx;
          end else begin
            state_d = GREEN;
            cur_d   = '0;
          end
        end
      end
      default: begin
        state_d = GREEN;
        cur_d   = '0;
      end
    endcase
  end

  // Timer restarts on every state change and saturates at the state limit.
  always_comb begin
    count_d = count_q;
    if (state_d != state_q) begin
      count_d = '0;
    end else if (tick && (count_q < limit)) begin
      count_d = count_q + TW'(1);
    end
  end

  // Request latches; clearing on service entry beats a same-edge request.
  always_comb begin
    veh_req_eff = veh_req;
    if (state_q == GREEN) veh_req_eff[cur_q] = 1'b0;
    veh_pend_d = veh_pend_q | veh_req_eff;
    if ((state_d == GREEN) && (state_q != GREEN)) veh_pend_d[cur_d] = 1'b0;

    ped_d = ped_q;
    if ((state_q != WALK) && ped_btn) ped_d = 1'b1;
    if ((state_d == WALK) && (state_q != WALK)) ped_d = 1'b0;
  end

  // State register with synchronous reset to main-road green.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GREEN;
      cur_q      <= '0;
      count_q    <= '0;
      veh_pend_q <= '0;
      ped_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      count_q    <= count_d;
      veh_pend_q <= veh_pend_d;
      ped_q      <= ped_d;
    end
  end

  // Lamp decode: only the served phase shows green or yellow.
  for (genvar gi = 0; gi < N_PHASE; gi++) begin : g_lamp
    assign light[2*gi +: 2] =
      ((cur_q == PW'(gi)) && (state_q == GREEN))  ? LAMP_GREEN  :
      ((cur_q == PW'(gi)) && (state_q == YELLOW)) ? LAMP_YELLOW :
                                                     LAMP_RED;
  end

  assign walk         = (state_q != WALK);
  assign active_phase = cur_q;
  assign ped_pending  = ped_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a per-cycle scoreboard.
// The stimulus thread pushes the hand-computed expected outputs for each cycle;
// a monitor thread pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] veh_req;
  logic       ped_btn;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic [7:0] light;
  logic       walk;
  logic [1:0] active_phase;
  logic       ped_pending;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected word: {light[7:0], walk, active_phase[1:0], ped_pending}
  logic [11:0] exp_q[$];
  string       name_q[$];

  traffic_phase_ctrl #(
    .N_PHASE      (4),
    .TW           (8),
    .T_GREEN_MAIN (6),
    .T_GREEN_SIDE (4),
    .T_YELLOW     (2),
    .T_ALLRED     (1),
    .T_WALK       (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .veh_req       (veh_req),
    .ped_btn       (ped_btn),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .light         (light),
    .walk          (walk),
    .active_phase  (active_phase),
    .ped_pending   (ped_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n clock edges; after each edge the outputs must equal the given values.
  task automatic seg(input int n, input logic [7:0] l, input logic w,
                     input logic [1:0] a, input logic p, input string nm);
    $display("[TB] %-18s %0d cycle(s) expect light=%b walk=%b phase=%0d ped=%b",
             nm, n, l, w, a, p);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back({l, w, a, p});
      name_q.push_back(nm);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard, away from the active edge.
  initial begin
    logic [11:0] e;
    logic [11:0] got;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {light, walk, active_phase, ped_pending};
        tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL %s: got light=%b walk=%b phase=%0d ped=%b, expected light=%b walk=%b phase=%0d ped=%b",
                   nm, got[11:4], got[3], got[2:1], got[0], e[11:4], e[3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // Lamp words: G<p> = phase p green, Y<p> = phase p yellow, 8'h55 = all red.
  initial begin
    rst = 1'b1; tick = 1'b1; veh_req = 4'b0000; ped_btn = 1'b0;
    preempt = 1'b0; preempt_phase = 2'd0;

    // 1: reset and idle rest on main road, own-phase request ignored
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "reset");
    rst = 1'b0;
    seg(10, 8'h54, 1'b1, 2'd0, 1'b0, "s1_idle_a");
    veh_req = 4'b0001;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s1_req_own");
    veh_req = 4'b0000;
    seg(19, 8'h54, 1'b1, 2'd0, 1'b0, "s1_idle_b");

    // 2: single request for phase 2
    veh_req = 4'b0100;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s2_latch");
    veh_req = 4'b0000;
    seg(3, 8'h56, 1'b1, 2'd0, 1'b0, "s2_y0");
    seg(2, 8'h55, 1'b1, 2'd0, 1'b0, "s2_ar0");
    seg(5, 8'h45, 1'b1, 2'd2, 1'b0, "s2_g2");
    seg(3, 8'h65, 1'b1, 2'd2, 1'b0, "s2_y2");
    seg(2, 8'h55, 1'b1, 2'd2, 1'b0, "s2_ar2");
    seg(7, 8'h54, 1'b1, 2'd0, 1'b0, "s2_g0");

    // 3: phases 1 and 3 together, served round-robin
    veh_req = 4'b1010;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s3_latch");
    veh_req = 4'b0000;
    seg(3, 8'h56, 1'b1, 2'd0, 1'b0, "s3_y0");
    seg(2, 8'h55, 1'b1, 2'd0, 1'b0, "s3_ar0");
    seg(5, 8'h51, 1'b1, 2'd1, 1'b0, "s3_g1");
    seg(3, 8'h59, 1'b1, 2'd1, 1'b0, "s3_y1");
    seg(2, 8'h55, 1'b1, 2'd1, 1'b0, "s3_ar1");
    seg(5, 8'h15, 1'b1, 2'd3, 1'b0, "s3_g3");
    seg(3, 8'h95, 1'b1, 2'd3, 1'b0, "s3_y3");
    seg(2, 8'h55, 1'b1, 2'd3, 1'b0, "s3_ar3");
    seg(7, 8'h54, 1'b1, 2'd0, 1'b0, "s3_g0");

    // 4: pedestrian during phase 1 green; button held across WALK entry and exit
    veh_req = 4'b0010;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s4_latch");
    veh_req = 4'b0000;
    seg(3, 8'h56, 1'b1, 2'd0, 1'b0, "s4_y0");
    seg(2, 8'h55, 1'b1, 2'd0, 1'b0, "s4_ar0");
    seg(1, 8'h51, 1'b1, 2'd1, 1'b0, "s4_g1_c0");
    ped_btn = 1'b1;
    seg(1, 8'h51, 1'b1, 2'd1, 1'b1, "s4_ped_latch");
    ped_btn = 1'b0;
    seg(3, 8'h51, 1'b1, 2'd1, 1'b1, "s4_g1");
    seg(3, 8'h59, 1'b1, 2'd1, 1'b1, "s4_y1");
    seg(2, 8'h55, 1'b1, 2'd1, 1'b1, "s4_ar1");
    ped_btn = 1'b1;
    seg(4, 8'h55, 1'b0, 2'd1, 1'b0, "s4_walk");
    seg(1, 8'h55, 1'b1, 2'd1, 1'b0, "s4_ar_w_c0");
    ped_btn = 1'b0;
    seg(1, 8'h55, 1'b1, 2'd1, 1'b0, "s4_ar_w_c1");
    seg(7, 8'h54, 1'b1, 2'd0, 1'b0, "s4_g0");

    // 5: preempt to phase 3 at phase 1 count 1, with ped and same-edge veh_req[3]
    veh_req = 4'b0010;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s5_latch");
    veh_req = 4'b0000;
    seg(3, 8'h56, 1'b1, 2'd0, 1'b0, "s5_y0");
    seg(2, 8'h55, 1'b1, 2'd0, 1'b0, "s5_ar0");
    seg(2, 8'h51, 1'b1, 2'd1, 1'b0, "s5_g1");
    preempt = 1'b1; preempt_phase = 2'd3;
    seg(1, 8'h59, 1'b1, 2'd1, 1'b0, "s5_y1_cut");
    ped_btn = 1'b1;
    seg(1, 8'h59, 1'b1, 2'd1, 1'b1, "s5_y1_ped");
    ped_btn = 1'b0;
    seg(1, 8'h59, 1'b1, 2'd1, 1'b1, "s5_y1_full");
    seg(2, 8'h55, 1'b1, 2'd1, 1'b1, "s5_ar1");
    veh_req = 4'b1000;
    seg(1, 8'h15, 1'b1, 2'd3, 1'b1, "s5_g3_entry");
    veh_req = 4'b0000;
    seg(9, 8'h15, 1'b1, 2'd3, 1'b1, "s5_g3_hold");
    preempt = 1'b0;
    seg(3, 8'h95, 1'b1, 2'd3, 1'b1, "s5_y3");
    seg(2, 8'h55, 1'b1, 2'd3, 1'b1, "s5_ar3");
    seg(4, 8'h55, 1'b0, 2'd3, 1'b0, "s5_walk");
    seg(2, 8'h55, 1'b1, 2'd3, 1'b0, "s5_ar_w");
    seg(12, 8'h54, 1'b1, 2'd0, 1'b0, "s5_g0_stay");

    // 6: reset in the middle of WALK with a vehicle request pending
    ped_btn = 1'b1;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b1, "s6_ped");
    ped_btn = 1'b0;
    seg(3, 8'h56, 1'b1, 2'd0, 1'b1, "s6_y0");
    seg(2, 8'h55, 1'b1, 2'd0, 1'b1, "s6_ar0");
    seg(1, 8'h55, 1'b0, 2'd0, 1'b0, "s6_walk_c0");
    veh_req = 4'b0100;
    seg(1, 8'h55, 1'b0, 2'd0, 1'b0, "s6_walk_c1");
    veh_req = 4'b0000;
    rst = 1'b1;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s6_rst");
    rst = 1'b0;
    seg(12, 8'h54, 1'b1, 2'd0, 1'b0, "s6_g0_clear");

    // 7: timer only advances on tick
    rst = 1'b1;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s7_rst");
    rst = 1'b0; tick = 1'b0; veh_req = 4'b0010;
    seg(1, 8'h54, 1'b1, 2'd0, 1'b0, "s7_latch");
    veh_req = 4'b0000;
    seg(9, 8'h54, 1'b1, 2'd0, 1'b0, "s7_frozen");
    tick = 1'b1;
    seg(6, 8'h54, 1'b1, 2'd0, 1'b0, "s7_run");
    seg(3, 8'h56, 1'b1, 2'd0, 1'b0, "s7_y0");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
